// File: rtl/effect_looper.sv
// Loop recorder/player stage: records the delay-effect output into SRAM and
// replays it mixed with the live signal, owning the SRAM port only while busy.
module effect_looper #(
   parameter logic [19:0] BASE_ADDR   = 20'h80000,
   parameter logic [19:0] MAX_SAMPLES = 20'h7FFFF
) (
   input  logic               i_AUD_BCLK,
   input  logic               i_rst_n,
   input  logic               i_valid,
   input  logic signed [15:0] i_data,
   input  logic               i_key,
   input  logic [2:0]         i_level,
   input  logic signed [15:0] i_sram_rdata,
   output logic [19:0]        o_sram_addr,
   output logic               o_sram_we_n,
   output logic [15:0]        o_sram_wdata,
   output logic               o_sram_busy,
   output logic signed [15:0] o_data,
   output logic               o_valid,
   output logic [1:0]         o_mode,
   output logic               o_overrun
);

   typedef enum logic [1:0] {
      MODE_IDLE   = 2'd0,
      MODE_RECORD = 2'd1,
      MODE_PLAY   = 2'd2
   } mode_e;

   mode_e              mode_q, mode_d, smode_q, smode_d;
   logic [1:0]         stg_q, stg_d;
   logic               pend_q, pend_d;
   logic [19:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, loop_len_q, loop_len_d;
   logic signed [15:0] live_q, live_d;
   logic [19:0]        addr_q, addr_d;
   logic               we_n_q, we_n_d, busy_q, busy_d;
   logic [15:0]        wdata_q, wdata_d;
   logic signed [15:0] data_q, data_d;
   logic               valid_q, valid_d, overrun_q, overrun_d;
   logic               accept, key_now, apply_key;

   function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
      if (v > 20'sd32767)
         sat16 = 16'sh7FFF;
      else if (v < -20'sd32768)
         sat16 = 16'sh8000;
      else
         sat16 = v[15:0];
   endfunction

   // live + (loop * (level+1)) >>> 3, in a 20-bit signed intermediate
   function automatic logic signed [15:0] mix(input logic signed [15:0] live,
                                              input logic signed [15:0] loop,
                                              input logic [2:0]         lvl);
      logic signed [19:0] gain, prod, sum;
      gain = $signed({16'd0, ({1'b0, lvl} + 4'd1)});
      prod = $signed({{4{loop[15]}}, loop}) * gain;
      sum  = $signed({{4{live[15]}}, live}) + (prod >>> 3);
      mix  = sat16(sum);
   endfunction

   always_comb begin
      mode_d     = mode_q;
      smode_d    = smode_q;
      stg_d      = stg_q;
      pend_d     = pend_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      loop_len_d = loop_len_q;
      live_d     = live_q;
      addr_d     = addr_q;
      we_n_d     = we_n_q;
      busy_d     = busy_q;
      wdata_d    = wdata_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      overrun_d  = overrun_q;

      accept  = i_valid && (stg_q == 2'd0);
      key_now = i_key || pend_q;

      if (i_valid && (stg_q != 2'd0))
         overrun_d = 1'b1;

      unique case (stg_q)
         2'd0: begin
            if (accept) begin
               stg_d   = 2'd1;
               smode_d = mode_q;
               live_d  = i_data;
               if (mode_q != MODE_IDLE) begin
                  busy_d = 1'b1;
                  addr_d = BASE_ADDR + ((mode_q == MODE_RECORD) ? wr_ptr_q : rd_ptr_q);
                  we_n_d = (mode_q != MODE_RECORD);
                  if (mode_q == MODE_RECORD)
                     wdata_d = i_data;
               end
            end
         end
         2'd1: begin
            stg_d  = 2'd2;
            we_n_d = 1'b1;
            if (smode_q == MODE_RECORD) begin
               // A full loop region ends recording on its own
               if (wr_ptr_q == MAX_SAMPLES - 20'd1) begin
                  mode_d     = MODE_PLAY;
                  loop_len_d = MAX_SAMPLES;
                  rd_ptr_d   = 20'd0;
                  wr_ptr_d   = 20'd0;
               end else begin
                  wr_ptr_d = wr_ptr_q + 20'd1;
               end
            end
         end
         2'd2: begin
            stg_d   = 2'd3;
            busy_d  = 1'b0;
            addr_d  = 20'd0;
            valid_d = 1'b1;
            if (smode_q == MODE_PLAY) begin
               data_d   = mix(live_q, i_sram_rdata, i_level);
               rd_ptr_d = (rd_ptr_q + 20'd1 == loop_len_q) ? 20'd0 : rd_ptr_q + 20'd1;
            end else begin
               data_d = live_q;
            end
         end
         default: stg_d = 2'd0;
      endcase

      // Keys act only between samples; otherwise one press is held until o_valid
      apply_key = key_now && (((stg_q == 2'd0) && !accept) || (stg_q == 2'd3));
      if (((stg_q == 2'd0) && !accept) || (stg_q == 2'd3))
         pend_d = 1'b0;
      else
         pend_d = key_now;

      if (apply_key) begin
         unique case (mode_q)
            MODE_IDLE: begin
               mode_d   = MODE_RECORD;
               wr_ptr_d = 20'd0;
            end
            MODE_RECORD: begin
               mode_d     = (wr_ptr_q == 20'd0) ? MODE_IDLE : MODE_PLAY;
               loop_len_d = wr_ptr_q;
               rd_ptr_d   = 20'd0;
            end
            default: mode_d = MODE_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mode_q     <= MODE_IDLE;
         smode_q    <= MODE_IDLE;
         stg_q      <= 2'd0;
         pend_q     <= 1'b0;
         wr_ptr_q   <= 20'd0;
         rd_ptr_q   <= 20'd0;
         loop_len_q <= 20'd0;
         live_q     <= 16'sd0;
         addr_q     <= 20'd0;
         we_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         wdata_q    <= 16'd0;
         data_q     <= 16'sd0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         smode_q    <= smode_d;
         stg_q      <= stg_d;
         pend_q     <= pend_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         loop_len_q <= loop_len_d;
         live_q     <= live_d;
         addr_q     <= addr_d;
         we_n_q     <= we_n_d;
         busy_q     <= busy_d;
         wdata_q    <= wdata_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign o_sram_addr  = addr_q;
   assign o_sram_we_n  = we_n_q;
   assign o_sram_wdata = wdata_q;
   assign o_sram_busy  = busy_q;
   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_mode       = mode_q;
   assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_effect_looper.sv
// Bench for effect_looper: randomized and directed samples against a queue-based
// model of the looper, with a small SRAM model behind the port.
module tb_effect_looper;

   localparam logic [19:0] BASE = 20'h80000;
   localparam int          MAXS = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic [15:0] i_data = 16'd0;
   logic        i_key = 1'b0;
   logic [2:0]  i_level = 3'd7;
   logic [15:0] i_sram_rdata;
   logic [19:0] o_sram_addr;
   logic        o_sram_we_n;
   logic [15:0] o_sram_wdata;
   logic        o_sram_busy;
   logic [15:0] o_data;
   logic        o_valid;
   logic [1:0]  o_mode;
   logic        o_overrun;

   effect_looper #(.BASE_ADDR(BASE), .MAX_SAMPLES(20'(MAXS))) dut (
      .i_AUD_BCLK(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
      .i_key(i_key), .i_level(i_level), .i_sram_rdata(i_sram_rdata),
      .o_sram_addr(o_sram_addr), .o_sram_we_n(o_sram_we_n), .o_sram_wdata(o_sram_wdata),
      .o_sram_busy(o_sram_busy), .o_data(o_data), .o_valid(o_valid),
      .o_mode(o_mode), .o_overrun(o_overrun)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:15];
   assign i_sram_rdata = mem[o_sram_addr[3:0]];
   always @(posedge clk)
      if (!o_sram_we_n) mem[o_sram_addr[3:0]] <= o_sram_wdata;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: 0=IDLE 1=RECORD 2=PLAY
   int m_mode;
   int m_rec[$];
   int m_loop[$];
   int m_rd;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_mix(input int live, input int loop, input int lvl);
      int p, sh, s;
      p  = loop * (lvl + 1);
      sh = (p >= 0) ? p / 8 : -((-p + 7) / 8);
      s  = live + sh;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   function automatic int rnd16();
      logic signed [15:0] r;
      r = 16'($urandom);
      return int'(r);
   endfunction

   task automatic model_key();
      case (m_mode)
         0: begin m_mode = 1; m_rec.delete(); end
         1: begin
            if (m_rec.size() == 0) m_mode = 0;
            else begin m_mode = 2; m_loop = m_rec; m_rd = 0; end
         end
         default: m_mode = 0;
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0; i_valid = 1'b0; i_key = 1'b0;
      tick();
      rst_n = 1'b1;
      m_mode = 0; m_rec.delete(); m_loop.delete(); m_rd = 0;
      tick();
   endtask

   task automatic press_key(input string nm);
      i_key = 1'b1;
      tick();
      i_key = 1'b0;
      model_key();
      n_vec++;
      if (o_mode !== 2'(m_mode)) begin
         n_err++; $display("FAIL %s mode: got %0d want %0d", nm, o_mode, m_mode);
      end
   endtask

   task automatic send_sample(input int data, input bit key, input string nm);
      int exp_out, exp_addr;
      bit exp_busy, exp_we_n;
      int old_mode;
      old_mode = m_mode;
      exp_busy = 1'b0; exp_we_n = 1'b1; exp_addr = 0; exp_out = data;
      if (m_mode == 1) begin
         exp_busy = 1'b1; exp_we_n = 1'b0;
         exp_addr = int'(BASE) + m_rec.size();
         m_rec.push_back(data);
         if (m_rec.size() == MAXS) begin m_mode = 2; m_loop = m_rec; m_rd = 0; end
      end else if (m_mode == 2) begin
         exp_busy = 1'b1;
         exp_addr = int'(BASE) + m_rd;
         exp_out  = ref_mix(data, m_loop[m_rd], int'(i_level));
         m_rd     = (m_rd + 1) % m_loop.size();
      end
      i_valid = 1'b1; i_data = 16'(data); i_key = key;
      tick();
      i_valid = 1'b0; i_key = 1'b0;
      n_vec++;
      if (o_sram_busy !== exp_busy || (exp_busy && (o_sram_addr !== 20'(exp_addr)
          || o_sram_we_n !== exp_we_n))) begin
         n_err++; $display("FAIL %s t1: busy=%b addr=%h we_n=%b want busy=%b addr=%h we_n=%b",
            nm, o_sram_busy, o_sram_addr, o_sram_we_n, exp_busy, exp_addr[19:0], exp_we_n);
      end
      if (old_mode == 1) begin
         n_vec++;
         if (o_sram_wdata !== 16'(data)) begin
            n_err++; $display("FAIL %s wdata: got %h want %h", nm, o_sram_wdata, 16'(data));
         end
      end
      tick();
      n_vec++;
      if (o_sram_busy !== exp_busy || o_sram_we_n !== 1'b1 || o_valid !== 1'b0) begin
         n_err++; $display("FAIL %s t2: busy=%b we_n=%b valid=%b want busy=%b we_n=1 valid=0",
            nm, o_sram_busy, o_sram_we_n, o_valid, exp_busy);
      end
      tick();
      n_vec++;
      if (o_valid !== 1'b1 || o_data !== 16'(exp_out) || o_sram_busy !== 1'b0
          || o_mode !== 2'(m_mode)) begin
         n_err++; $display("FAIL %s t3: valid=%b data=%0d busy=%b mode=%0d want 1 %0d 0 %0d",
            nm, o_valid, $signed(o_data), o_sram_busy, o_mode, exp_out, m_mode);
      end
      tick();
      if (key) model_key();
      n_vec++;
      if (o_valid !== 1'b0 || o_mode !== 2'(m_mode)) begin
         n_err++; $display("FAIL %s t4: valid=%b mode=%0d want 0 %0d", nm, o_valid, o_mode, m_mode);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_vec++;
      if (o_sram_addr !== 20'd0 || o_sram_we_n !== 1'b1 || o_sram_wdata !== 16'd0 ||
          o_sram_busy !== 1'b0 || o_data !== 16'd0 || o_valid !== 1'b0 ||
          o_mode !== 2'd0 || o_overrun !== 1'b0) begin
         n_err++; $display("FAIL reset: addr=%h we_n=%b wd=%h busy=%b data=%h v=%b mode=%0d ovr=%b",
            o_sram_addr, o_sram_we_n, o_sram_wdata, o_sram_busy, o_data, o_valid, o_mode, o_overrun);
      end
      do_reset();
   endtask

   task automatic test_idle_passthrough();
      send_sample(int'(16'h1234), 1'b0, "idle_1234");
      for (int i = 0; i < 3; i++) send_sample(rnd16(), 1'b0, "idle_rand");
   endtask

   task automatic test_record_play();
      do_reset();
      press_key("rec_enter");
      for (int i = 1; i <= 4; i++) send_sample(100 * i, 1'b0, "rec_100s");
      press_key("play_enter");
      i_level = 3'd7;
      for (int i = 0; i < 5; i++) send_sample(0, 1'b0, "play_wrap");
      press_key("play_exit");
   endtask

   task automatic test_saturation();
      do_reset();
      press_key("sat_rec");
      send_sample(10000, 1'b0, "sat_rec0");
      send_sample(-10000, 1'b0, "sat_rec1");
      press_key("sat_play");
      i_level = 3'd7;
      send_sample(30000, 1'b0, "sat_pos");
      send_sample(-30000, 1'b0, "sat_neg");
   endtask

   task automatic test_key_with_valid();
      do_reset();
      press_key("kv_rec");
      send_sample(11, 1'b0, "kv_s0");
      send_sample(22, 1'b1, "kv_s1_key");
      i_level = 3'd3;
      for (int i = 0; i < 3; i++) send_sample(rnd16(), 1'b0, "kv_play");
   endtask

   task automatic test_empty_and_double_key();
      do_reset();
      press_key("empty_rec");
      press_key("empty_exit");
      // valid+key, then a second key while the first is pending
      i_valid = 1'b1; i_data = 16'd5; i_key = 1'b1;
      tick();
      i_valid = 1'b0; i_key = 1'b0;
      tick();
      i_key = 1'b1;
      tick();
      i_key = 1'b0;
      n_vec++;
      if (o_valid !== 1'b1 || o_data !== 16'd5 || o_mode !== 2'd0) begin
         n_err++; $display("FAIL dbl_key t3: valid=%b data=%0d mode=%0d want 1 5 0", o_valid, o_data, o_mode);
      end
      tick();
      tick();
      model_key();
      n_vec++;
      if (o_mode !== 2'(m_mode)) begin
         n_err++; $display("FAIL dbl_key mode: got %0d want %0d", o_mode, m_mode);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      n_vec++;
      if (o_overrun !== 1'b0) begin
         n_err++; $display("FAIL ovr_clear: got %b want 0", o_overrun);
      end
      i_valid = 1'b1; i_data = 16'd77;
      tick();
      i_data = 16'd88;
      tick();
      i_valid = 1'b0;
      n_vec++;
      if (o_overrun !== 1'b1) begin
         n_err++; $display("FAIL ovr_set: got %b want 1", o_overrun);
      end
      tick();
      n_vec++;
      if (o_valid !== 1'b1 || o_data !== 16'd77) begin
         n_err++; $display("FAIL ovr_first: valid=%b data=%0d want 1 77", o_valid, o_data);
      end
      tick();
      n_vec++;
      if (o_valid !== 1'b0) begin
         n_err++; $display("FAIL ovr_dropped: valid=%b want 0", o_valid);
      end
      send_sample(-55, 1'b0, "ovr_next");
      n_vec++;
      if (o_overrun !== 1'b1) begin
         n_err++; $display("FAIL ovr_sticky: got %b want 1", o_overrun);
      end
   endtask

   task automatic test_reset_mid_access();
      do_reset();
      press_key("mid_rec");
      i_valid = 1'b1; i_data = 16'd9;
      tick();
      i_valid = 1'b0;
      n_vec++;
      if (o_sram_we_n !== 1'b0 || o_sram_busy !== 1'b1) begin
         n_err++; $display("FAIL mid_pre: we_n=%b busy=%b want 0 1", o_sram_we_n, o_sram_busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (o_sram_we_n !== 1'b1 || o_sram_busy !== 1'b0 || o_mode !== 2'd0) begin
         n_err++; $display("FAIL mid_rst: we_n=%b busy=%b mode=%0d want 1 0 0", o_sram_we_n, o_sram_busy, o_mode);
      end
      do_reset();
   endtask

   task automatic test_auto_exit();
      do_reset();
      press_key("auto_rec");
      for (int i = 0; i < MAXS; i++) send_sample(rnd16(), 1'b0, "auto_rec_s");
      i_level = 3'($urandom_range(0, 7));
      for (int i = 0; i < MAXS + 2; i++) send_sample(rnd16(), 1'b0, "auto_play");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int n;
         do_reset();
         press_key("rnd_rec");
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) send_sample(rnd16(), (i == n - 1) && r[0], "rnd_rec_s");
         if (!r[0]) press_key("rnd_play");
         i_level = 3'($urandom_range(0, 7));
         for (int i = 0; i < int'($urandom_range(3, 10)); i++) send_sample(rnd16(), 1'b0, "rnd_play_s");
         press_key("rnd_exit");
         send_sample(rnd16(), 1'b0, "rnd_idle");
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'd0;
      test_reset();
      test_idle_passthrough();
      test_record_play();
      test_saturation();
      test_key_with_valid();
      test_empty_and_double_key();
      test_overrun();
      test_reset_mid_access();
      test_auto_exit();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
